irq_inject: RTL

- Guest-facing interrupt injector for the Nabu MegaMapper; the delivery end of the interrupt path that the trap logic intercepts.
- Hypervisor code queues interrupt vector bytes through mapper I/O writes.
- Block holds guest irq_n low while vectors are pending, answers the guest's interrupt-acknowledge cycle by driving the head vector onto the data bus, then pops it.
- Sits beside the trap/register logic, sharing the Z80 bus; its irq_n output is ANDed into the guest IRQ line at top level.

---
 rtl/irq_inject.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/irq_inject.sv
// Guest interrupt injector: queues hypervisor-written vector bytes, holds irq_n low while
// any are pending, and answers the Z80 interrupt-acknowledge cycle with the head vector.
// Build option IRQINJ_DEFAULT_VECTOR_EN: an acknowledge with an empty queue drives 0xFF and
// status bit 7 reports spurious_ack instead of ovf.
//
//  state  | meaning
//  IDLE   | waiting for an acknowledge; irq_n may be asserted
//  ACK    | acknowledge in progress, latched vector driven while inta is high
//  DONE   | one-clk gap after the pop before irq_n is re-evaluated
module irq_inject #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic       wr_n,
    input  logic       rd_n,
    input  logic       iorq_n,
    input  logic       m1_n,
    input  logic       reg_sel,
    input  logic       lo_addr0,
    output logic       irq_n
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef IRQINJ_DEFAULT_VECTOR_EN
    localparam logic [7:0] EMPTY_VEC   = 8'hFF;
    localparam logic       EMPTY_DRIVE = 1'b1;
`else
    localparam logic [7:0] EMPTY_VEC   = 8'h00;
    localparam logic       EMPTY_DRIVE = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_enable;
    logic             r_ovf;
    logic             r_spurious;
    logic             r_wr_lvl;
    logic             r_rd_lvl;
    logic [7:0]       r_ack_vec;
    logic             r_ack_drive;
    logic             r_pop_pend;
    logic             r_irq_n;

    logic       w_io_cyc;
    logic       w_wr_lvl;
    logic       w_rd_lvl;
    logic       w_wr_ev;
    logic       w_rd_ev;
    logic       w_inta;
    logic       w_empty;
    logic       w_full;
    logic       w_flush;
    logic       w_push_req;
    logic       w_push;
    logic       w_pop;
    logic       w_stat_rd_ev;
    logic [7:0] w_head;
    logic [3:0] w_cnt4;
    logic       w_stat_b7;
    logic [7:0] w_status;

    assign w_io_cyc     = reg_sel & ~iorq_n & m1_n;
    assign w_wr_lvl     = w_io_cyc & ~wr_n;
    assign w_rd_lvl     = w_io_cyc & ~rd_n;
    // One event per bus cycle no matter how many wait states stretch the strobe.
    assign w_wr_ev      = w_wr_lvl & ~r_wr_lvl;
    assign w_rd_ev      = w_rd_lvl & ~r_rd_lvl;
    assign w_inta       = ~m1_n & ~iorq_n;
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CNT_W'(DEPTH));
    assign w_flush      = w_wr_ev & lo_addr0 & data_in[1];
    assign w_push_req   = w_wr_ev & ~lo_addr0;
    assign w_pop        = (r_state == S_ACK) & ~w_inta & r_pop_pend & ~w_flush;
    assign w_push       = w_push_req & (~w_full | w_pop) & ~w_flush;
    assign w_stat_rd_ev = w_rd_ev & lo_addr0;
    assign w_head       = r_mem[r_rd_ptr];
    assign w_cnt4       = 4'(r_count);

`ifdef IRQINJ_DEFAULT_VECTOR_EN
    assign w_stat_b7 = r_spurious;
`else
    assign w_stat_b7 = r_ovf;
`endif

    assign w_status = {w_stat_b7, r_enable, w_empty, w_full, w_cnt4};
    assign irq_n    = r_irq_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_lvl <= 1'b0;
            r_rd_lvl <= 1'b0;
        end else begin
            r_wr_lvl <= w_wr_lvl;
            r_rd_lvl <= w_rd_lvl;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enable   <= 1'b0;
            r_ovf      <= 1'b0;
            r_spurious <= 1'b0;
        end else begin
            if (w_wr_ev && lo_addr0) r_enable <= data_in[0];
            if (w_push_req && w_full && !w_pop && !w_flush) r_ovf <= 1'b1;
            else if (w_stat_rd_ev)                          r_ovf <= 1'b0;
            if (r_state == S_IDLE && w_inta && w_empty) r_spurious <= 1'b1;
            else if (w_stat_rd_ev)                      r_spurious <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_ack_vec   <= 8'h00;
            r_ack_drive <= 1'b0;
            r_pop_pend  <= 1'b0;
            r_irq_n     <= 1'b1;
        end else begin
            r_irq_n <= ~(r_enable & ~w_empty & (r_state == S_IDLE));
            case (r_state)
                S_IDLE: begin
                    if (w_inta) begin
                        r_state     <= S_ACK;
                        r_ack_vec   <= w_empty ? EMPTY_VEC : w_head;
                        r_ack_drive <= ~w_empty | EMPTY_DRIVE;
                        r_pop_pend  <= ~w_empty & ~w_flush;
                    end
                end
                S_ACK: begin
                    if (w_flush) r_pop_pend <= 1'b0;
                    if (!w_inta) begin
                        r_state    <= S_DONE;
                        r_pop_pend <= 1'b0;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The vector is presented from the very start of inta, before the FSM has left IDLE.
    always_comb begin
        data_out = 8'h00;
        data_oe  = 1'b0;
        if (reset_n && w_inta) begin
            if (r_state == S_IDLE) begin
                data_out = w_empty ? EMPTY_VEC : w_head;
                data_oe  = ~w_empty | EMPTY_DRIVE;
            end else if (r_state == S_ACK) begin
                data_out = r_ack_vec;
                data_oe  = r_ack_drive;
            end
        end else if (reset_n && w_rd_lvl) begin
            data_out = lo_addr0 ? w_status : w_head;
            data_oe  = 1'b1;
        end
    end

endmodule
